pipeline_ctrl: RTL
==================

# pipeline_ctrl

Hazard and sequencing controller for the 5-stage RV32 pipeline (F=0, D=1, E=2, M=3, W=4). It drives the per-stage stall/flush vectors and the E-stage operand-forwarding selects. It sequences multi-cycle multiplies in E through a small state machine and freezes the pipe on data-memory wait states. It also keeps a saturating stall-cycle performance counter.

## Interface
- N_STAGES, 5, number of pipeline stages; stall/flush vector width
- MUL_LATENCY, 4, total E-stage cycles a multiply occupies (including issue cycle); legal range 2..16
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset; one clock, asynchronous, active-low
- rs1_d, rs2_d  in  5  source registers of instruction in D
- rs1_e, rs2_e, rd_e  in  5  source/dest registers of instruction in E
- rd_m, rd_w  in  5  dest registers in M, W
- reg_write_e, reg_write_m, reg_write_w  in  1  stage instruction writes rd
- mem_read_e  in  1  instruction in E is a load
- mul_start_e  in  1  instruction in E is a multiply
- branch_hit  in  1  E resolved a taken branch/jump
- mem_req_m  in  1  M is issuing a data-memory access
- mem_ack  in  1  data memory completes access this cycle
- stalls  out  N_STAGES  hold stage register
- flushes  out  N_STAGES  load bubble into stage register
- r1_e_sel, r2_e_sel  out  2  0=register file, 1=forward M alu_res, 2=forward W write_back
- mul_done  out  1  multiply result valid in E this cycle
- mul_busy  out  1  state is MUL_BUSY or MUL_HOLD
- stall_cnt  out  32  cycles with stalls[0]=1, saturating

## Operation
- mem_wait = mem_req_m & ~mem_ack. When asserted: stalls[0..3]=1, flushes[4]=1. Highest priority.
- Load-use = mem_read_e & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d). When asserted and no mem_wait: stalls[0..1]=1, flushes[2]=1.
- FSM states: IDLE, MUL_BUSY, MUL_HOLD. Down-counter cnt is 4 bits.
  - IDLE: on mul_start_e & ~mem_wait, go to MUL_BUSY and load cnt=MUL_LATENCY-2. This cycle assert stalls[0..2]=1, flushes[3]=1.
  - MUL_BUSY with cnt!=0: decrement cnt every cycle, including during mem_wait. Assert stalls[0..2]=1, flushes[3]=1.
  - MUL_BUSY with cnt==0:
    - If ~mem_wait: mul_done=1, no mul stall, go to IDLE.
    - Else go to MUL_HOLD.
  - MUL_HOLD: keep stalling through mem_wait. On the first ~mem_wait cycle assert mul_done=1 and go to IDLE.
- branch_hit: flushes[1]=1 and flushes[2]=1, only when E is not stalled (no mem_wait, no mul stall). Otherwise ignore; the datapath holds branch_hit while E is frozen.
- Forwarding, evaluated for rs1_e and rs2_e independently:
  - Select 1 if reg_write_m & rd_m!=0 & rd_m==rsX_e.
  - Else select 2 if reg_write_w & rd_w!=0 & rd_w==rsX_e.
  - Else select 0.
  - M wins over W.
- Output composition: stalls and flushes are the OR of all active sources. A stage is never both stalled and flushed by the same source. When a stalled stage also receives a flush, stall wins.
- stall_cnt: +1 per cycle with stalls[0]=1; holds at 32'hFFFF_FFFF.

## Timing
- stalls, flushes, r1/r2_e_sel, mul_done are combinational from inputs and current state; the datapath samples them at the same edge.
- Reset (rst_n=0, asynchronous):
  - state=IDLE, cnt=0, stall_cnt=0.
  - stalls=0, flushes all 1, mul_done=0, mul_busy=0.
  - Selects follow their inputs.
- Multiply issued at cycle T with no memory waits:
  - Stalls held in cycles T..T+MUL_LATENCY-2.
  - mul_done in T+MUL_LATENCY-1.
  - E advances at the end of T+MUL_LATENCY-1.
- Back-to-back multiplies: the next mul_start_e is seen in IDLE the cycle after mul_done and is issued without a gap.
- Reset mid-multiply: the FSM returns to IDLE immediately, and no mul_done is produced.

## Test plan
- rd_m=rd_w=5, both reg_write, rs1_e=5 → r1_e_sel=1. Clear reg_write_m → 2. Set rd=0 → 0.
- Load in E with rd_e=7, rs2_d=7 → stalls=5'b00011, flushes=5'b00100 for exactly 1 cycle.
- mul_start_e at T, MUL_LATENCY=4 → stalls[2:0]=3'b111 and flushes[3]=1 in T..T+2; mul_done=1 only in T+3; mul_busy=1 in T+1..T+3.
- Multiply in flight, mem_req_m=1 with mem_ack=0 from T+1 to T+5 → MUL_HOLD entered. stalls=5'b01111 and flushes[4]=1 through T+5. mul_done=1 at T+6 only.
- branch_hit with no stall → flushes=5'b00110. branch_hit during mem_wait → flushes[2:1]=0.
- rst_n low during MUL_BUSY → outputs go to reset values asynchronously. After release, mul_done never fires. Also: stall_cnt preloaded near max via 2^32 forced stalls saturates at FFFF_FFFF.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline: stall/flush vectors,
// E-stage forwarding selects, multi-cycle multiply sequencing and a stall-cycle counter.
module pipeline_ctrl #(
    parameter int N_STAGES    = 5,
    parameter int MUL_LATENCY = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4:0]          rs1_d,
    input  logic [4:0]          rs2_d,
    input  logic [4:0]          rs1_e,
    input  logic [4:0]          rs2_e,
    input  logic [4:0]          rd_e,
    input  logic [4:0]          rd_m,
    input  logic [4:0]          rd_w,
    input  logic                reg_write_e,
    input  logic                reg_write_m,
    input  logic                reg_write_w,
    input  logic                mem_read_e,
    input  logic                mul_start_e,
    input  logic                branch_hit,
    input  logic                mem_req_m,
    input  logic                mem_ack,
    output logic [N_STAGES-1:0] stalls,
    output logic [N_STAGES-1:0] flushes,
    output logic [1:0]          r1_e_sel,
    output logic [1:0]          r2_e_sel,
    output logic                mul_done,
    output logic                mul_busy,
    output logic [31:0]         stall_cnt
);

    localparam int ST_F = 0;
    localparam int ST_D = 1;
    localparam int ST_E = 2;
    localparam int ST_M = 3;
    localparam int ST_W = 4;

    // Issue cycle and the final (done) cycle are not counted down.
    localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LATENCY - 2);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_HOLD = 2'd2
    } state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [31:0]         stall_cnt_q;
    logic [31:0]         stall_cnt_d;
    logic                mem_wait;
    logic                load_use;
    logic                mul_stall;
    logic                mul_done_c;
    logic [N_STAGES-1:0] stall_v;
    logic [N_STAGES-1:0] flush_v;

    // reg_write_e is part of the stage interface but load-use only needs mem_read_e.
    logic unused_ok;
    assign unused_ok = reg_write_e;

    assign mem_wait = mem_req_m & ~mem_ack;
    assign load_use = mem_read_e & (rd_e != 5'd0) & ((rd_e == rs1_d) | (rd_e == rs2_d));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mul_start_e && !mem_wait) begin
                        state_q <= MUL_BUSY;
                        cnt_q   <= MUL_CNT_INIT;
                    end
                end
                MUL_BUSY: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (mem_wait) begin
                        state_q <= MUL_HOLD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                MUL_HOLD: begin
                    if (!mem_wait) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        mul_stall  = 1'b0;
        mul_done_c = 1'b0;
        case (state_q)
            IDLE:     mul_stall = mul_start_e & ~mem_wait;
            MUL_BUSY: begin
                mul_stall  = (cnt_q != 4'd0) | mem_wait;
                mul_done_c = (cnt_q == 4'd0) & ~mem_wait;
            end
            MUL_HOLD: begin
                mul_stall  = mem_wait;
                mul_done_c = ~mem_wait;
            end
            default: ;
        endcase
    end

    always_comb begin
        stall_v = '0;
        flush_v = '0;
        if (mem_wait) begin
            stall_v[ST_F] = 1'b1;
            stall_v[ST_D] = 1'b1;
            stall_v[ST_E] = 1'b1;
            stall_v[ST_M] = 1'b1;
            flush_v[ST_W] = 1'b1;
        end
        if (load_use && !mem_wait) begin
            stall_v[ST_F] = 1'b1;
            stall_v[ST_D] = 1'b1;
            flush_v[ST_E] = 1'b1;
        end
        if (mul_stall) begin
            stall_v[ST_F] = 1'b1;
            stall_v[ST_D] = 1'b1;
            stall_v[ST_E] = 1'b1;
            flush_v[ST_M] = 1'b1;
        end
        // A frozen E keeps its branch; the datapath re-presents it once E moves.
        if (branch_hit && !mem_wait && !mul_stall) begin
            flush_v[ST_D] = 1'b1;
            flush_v[ST_E] = 1'b1;
        end
    end

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return 2'd1;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return 2'd2;
        end
        return 2'd0;
    endfunction

    assign r1_e_sel = fwd_sel(rs1_e);
    assign r2_e_sel = fwd_sel(rs2_e);

    // NOTE: during reset the combinational outputs are forced to the bubble-everything values.
    always_comb begin
        stalls   = '0;
        flushes  = '1;
        mul_done = 1'b0;
        if (rst_n) begin
            stalls   = stall_v;
            flushes  = flush_v & ~stall_v;
            mul_done = mul_done_c;
        end
    end

    assign mul_busy = (state_q == MUL_BUSY) || (state_q == MUL_HOLD);

    assign stall_cnt_d = (stall_v[ST_F] && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1
                                                                           : stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
